axi4_lite_reg_slave: RTL

Parametrised AXI4-Lite slave register bank with independent AW/W acceptance, byte strobes, BRESP/RRESP and a flat register output bus.
Sits behind axi4_top_module's master as the programmable control/status target, replacing the fixed-width single-beat slave.
Exports every register and a per-register write pulse to downstream logic.

---
 rtl/axi4_pkg.sv | 10 +
 rtl/axi4_reg_bank.sv | 33 +++
 rtl/axi4_lite_reg_slave.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared response codes, FSM state types and address-decode helper for the AXI4-Lite register slave
package axi4_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/axi4_reg_bank.sv
// axi4_reg_bank: register storage with byte-strobed write port, combinational read mux and flat export
module axi4_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_q
);
    logic [DATA_W-1:0] mem [NUM_REGS];
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) mem[i] <= '0;
            else if (we && wr_idx == IDX_W'(i))
                for (int b = 0; b < DATA_W / 8; b++)
                    if (wstrb[b]) mem[i][8*b +: 8] <= wdata[8*b +: 8];
        end
        assign regs_q[i*DATA_W +: DATA_W] = mem[i];
    end
    // out-of-range indices fall through to zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_idx == IDX_W'(i)) rdata = mem[i];
    end
endmodule

// File: rtl/axi4_lite_reg_slave.sv
// axi4_lite_reg_slave: AXI4-Lite register bank slave with independent AW/W capture and per-register write pulses
// Define AXIL_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_reg_slave
    import axi4_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int LSB    = addr_lsb(DATA_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int STRB_W = DATA_W / 8;
`ifdef AXIL_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    w_state_e w_state, w_next;
    r_state_e r_state, r_next;
    logic ready_en, aw_hs, w_hs, ar_hs, wr_done, wr_in_range, rd_in_range;
    logic [ADDR_W-1:0] awaddr_q, wr_addr;
    logic [DATA_W-1:0] wdata_q, wr_data, bank_rdata;
    logic [STRB_W-1:0] wstrb_q, wr_strb;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    // readies stay low until the first edge after reset release
    assign awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign wready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign arready = ready_en && r_state == R_IDLE;
    assign bvalid  = w_state == W_RESP;
    assign rvalid  = r_state == R_RESP;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    assign wr_addr     = aw_hs ? awaddr : awaddr_q;
    assign wr_data     = w_hs ? wdata : wdata_q;
    assign wr_strb     = w_hs ? wstrb : wstrb_q;
    assign wr_idx      = wr_addr[ADDR_W-1:LSB];
    assign rd_idx      = araddr[ADDR_W-1:LSB];
    assign wr_in_range = int'(wr_idx) < NUM_REGS;
    assign rd_in_range = int'(rd_idx) < NUM_REGS;

    always_comb begin
        w_next  = w_state;
        wr_done = 1'b0;
        case (w_state)
            W_IDLE: begin
                wr_done = aw_hs && w_hs;
                w_next  = wr_done ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
            end
            W_HAVE_AW: begin
                wr_done = w_hs;
                w_next  = w_hs ? W_RESP : W_HAVE_AW;
            end
            W_HAVE_W: begin
                wr_done = aw_hs;
                w_next  = aw_hs ? W_RESP : W_HAVE_W;
            end
            default: w_next = bready ? W_IDLE : W_RESP;
        endcase
    end

    always_comb begin
        r_next = r_state;
        r_next = r_state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (rready ? R_IDLE : R_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp    <= RESP_OKAY;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            wr_pulse <= '0;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_next;
            r_state  <= r_next;
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (wr_done) bresp <= wr_in_range ? RESP_OKAY : OOR_RESP;
            wr_pulse <= (wr_done && wr_in_range) ? NUM_REGS'(1) << wr_idx : '0;
            if (ar_hs) begin
                rdata <= rd_in_range ? bank_rdata : '0;
                rresp <= rd_in_range ? RESP_OKAY : OOR_RESP;
            end
        end
    end

    axi4_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_done && wr_in_range),
        .wr_idx  (wr_idx),
        .wdata   (wr_data),
        .wstrb   (wr_strb),
        .rd_idx  (rd_idx),
        .rdata   (bank_rdata),
        .regs_q  (regs_q)
    );
endmodule
